mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers.
- Sits beside the execute-stage ALU of the pipelined CPU.
- Accepts one start pulse and raises busy for a fixed latency, so the hazard unit stalls MF/MT and MD instructions.
- Adds multiply-accumulate (madd/msub) and explicit divide-by-zero/overflow handling that the single-cycle ALU lacks.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request; op and operands sampled at the same edge.
- op  in  4  operation code (see Behaviour).
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- busy  out  1  high while a multi-cycle operation is in flight.
- hi  out  WIDTH  HI register (registered output).
- lo  out  WIDTH  LO register (registered output).
- div_zero  out  1  one-cycle pulse at completion of a div/divu with B==0.

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, hi=0, lo=0, div_zero=0, counter=0; the in-flight result is discarded.
- op codes:
  - 0 mult, 1 multu, 2 div, 3 divu.
  - 4 madd, 5 maddu, 6 msub, 7 msubu.
  - 8 mthi, 9 mtlo.
  - 10-15 no-op: nothing changes, busy stays 0.
- Start rule:
  - start is honoured only when busy==0.
  - start while busy is ignored completely; the controller must stall.
- States: IDLE and RUN (counter-based).
- IDLE + start + multi-cycle op:
  - Operands and op are latched.
  - Result is computed from the latched values (combinational sub-module).
  - counter loads MULT_CYCLES or DIV_CYCLES; busy=1 from the next cycle.
- RUN:
  - counter decrements each edge.
  - At the edge where counter==1, hi/lo are written, busy goes 0 and the state returns to IDLE.
  - busy is therefore high for exactly N cycles. New hi/lo are visible in the first cycle busy==0.
  - A new start is accepted in that same cycle.
- mthi/mtlo:
  - Written at the start edge (hi<=A or lo<=A); busy never asserts.
  - The other register is unchanged.
- mult: {hi,lo} = signed A * signed B, 2*WIDTH-bit result.
- multu: unsigned product, same layout as mult.
- madd/maddu: {hi,lo} = {hi,lo} + product (signed/unsigned); wraps modulo 2^(2*WIDTH).
- msub/msubu: {hi,lo} = {hi,lo} - product; wraps modulo 2^(2*WIDTH).
- The accumulate base is the hi/lo value at the start edge.
- div:
  - lo = quotient truncated toward zero; hi = remainder, whose sign follows the dividend.
  - Overflow case A = most-negative, B = -1: lo = A, hi = 0; no flag.
- divu: unsigned quotient and remainder.
- Divide by zero (B==0):
  - busy still runs DIV_CYCLES.
  - hi/lo remain unchanged at completion.
  - div_zero pulses high for the completion cycle.
- There is no cancel input. The controller must not issue start for an instruction that is flushed by an exception in the same cycle.

Decomposition:
- Shared package (mdu_pkg) holds:
  - op code constants MDU_MULT..MDU_MTLO;
  - default cycle counts;
  - WIDTH default.
- One sub-module, mdu_compute: purely combinational.
  - Inputs: latched op, A, B, hi, lo.
  - Outputs: next hi/lo and a dz flag.
- mdu_unit holds the FSM, counter, latches and HI/LO registers.

Test Plan:
- Reset, then mult A=0xFFFFFFFF (-1), B=0x00000002 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu A=7, B=0 with prior hi=0x11, lo=0x22 -> hi/lo unchanged; div_zero pulses 1 cycle; div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi A=0, mtlo A=0xFFFFFFFF, then maddu A=1, B=1 -> hi=1, lo=0 (carry across); msub A=1, B=1 -> hi=0, lo=0xFFFFFFFF.
- Second start asserted while busy is ignored (hi/lo reflect the first op only); async reset asserted at cycle 3 of a mult -> busy=0, hi=lo=0 immediately, no later write.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default
// geometry and the controller state encoding.
package mdu_pkg;

    localparam int MDU_WIDTH       = 32;
    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MADD  = 4'd4;
    localparam logic [3:0] MDU_MADDU = 4'd5;
    localparam logic [3:0] MDU_MSUB  = 4'd6;
    localparam logic [3:0] MDU_MSUBU = 4'd7;
    localparam logic [3:0] MDU_MTHI  = 4'd8;
    localparam logic [3:0] MDU_MTLO  = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for the multiply latency
    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) ||
               (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

    // Ops that occupy the unit for the divide latency
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational datapath: given the latched op/operands and the current
// HI/LO, produce the HI/LO values to commit and the divide-by-zero flag.
module mdu_compute
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_dz
);

    logic               w_signed_mul;
    logic               w_signed_div;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_b_div;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic               w_q_neg;
    logic               w_r_neg;
    logic               w_b_zero;

    // A single 2W x 2W multiplier truncated to 2W bits gives both the signed
    // and unsigned product once the operands are extended appropriately.
    assign w_signed_mul = (i_op == MDU_MULT) || (i_op == MDU_MADD) || (i_op == MDU_MSUB);
    assign w_ext_a      = w_signed_mul ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
    assign w_ext_b      = w_signed_mul ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
    assign w_prod       = w_ext_a * w_ext_b;
    assign w_acc_base   = {i_hi, i_lo};

    // Signed divide is done on magnitudes with one shared unsigned divider.
    // The most-negative / -1 case falls out naturally: |A| = 2^(W-1) as an
    // unsigned value, quotient sign is positive, so LO = A and HI = 0.
    assign w_signed_div = (i_op == MDU_DIV);
    assign w_b_zero     = (i_b == '0);
    assign w_a_mag      = (w_signed_div && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag      = (w_signed_div && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_b_div      = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
    assign w_uq         = w_a_mag / w_b_div;
    assign w_ur         = w_a_mag % w_b_div;
    assign w_q_neg      = w_signed_div & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    assign w_r_neg      = w_signed_div & i_a[WIDTH-1];
    assign w_q          = w_q_neg ? -w_uq : w_uq;
    assign w_r          = w_r_neg ? -w_ur : w_ur;

    // Select the HI/LO update for the latched op; anything else holds HI/LO
    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        o_dz = 1'b0;
        case (i_op)
            MDU_MULT, MDU_MULTU: {o_hi, o_lo} = w_prod;
            MDU_MADD, MDU_MADDU: {o_hi, o_lo} = w_acc_base + w_prod;
            MDU_MSUB, MDU_MSUBU: {o_hi, o_lo} = w_acc_base - w_prod;
            MDU_DIV, MDU_DIVU: begin
                if (w_b_zero) begin
                    o_dz = 1'b1;
                end else begin
                    o_hi = w_r;
                    o_lo = w_q;
                end
            end
            default: begin
                o_dz = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. A start in IDLE
// latches op/operands, busy is held for a fixed latency, and HI/LO are
// committed on the final RUN edge. mthi/mtlo complete at the start edge.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = MDU_WIDTH,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output mdu_state_e       dbg_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div_zero;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic             w_dz;

    // HI/LO are stable during RUN (no writes are accepted while busy), so the
    // live registers are the accumulate base captured at the start edge.
    mdu_compute #(.WIDTH(WIDTH)) u_compute (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_hi_next),
        .o_lo (w_lo_next),
        .o_dz (w_dz)
    );

    // Controller FSM: accept starts in IDLE, count down in RUN, commit at count==1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mult_op(op) || is_div_op(op)) begin
                            r_op    <= op;
                            r_a     <= A;
                            r_b     <= B;
                            r_count <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            r_state <= ST_RUN;
                        end else if (op == MDU_MTHI) begin
                            r_hi <= A;
                        end else if (op == MDU_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_count == CNT_W'(1)) begin
                        r_hi       <= w_hi_next;
                        r_lo       <= w_lo_next;
                        r_div_zero <= w_dz;
                        r_count    <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign div_zero  = r_div_zero;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: a sequential vector table (each entry depends on the
// HI/LO left by the previous one), a few random unsigned ops against a
// 64-bit reference, and hand-written busy-stall and mid-op reset sequences.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;
    mdu_state_e   dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    logic [2*W:0] exp_q[$];

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         edz;
        int           ncyc;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (a),
        .B         (b),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Drive a one-cycle start and record the expected completion values.
    // Called just after a rising edge; returns just after the start edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        exp_q.push_back({edz, eh, el});
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd15;
        a     = '0;
        b     = '0;
        check("dz_clear", {31'b0, div_zero}, 32'd0);
    endtask

    // Count remaining busy cycles, then pop the scoreboard and compare.
    task automatic wait_done(input string tag, input int ncyc);
        int           cnt = 0;
        logic [2*W:0] e;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check({tag, ":busy_len"}, 32'(cnt), 32'(ncyc));
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s:scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ":hi"}, hi, e[2*W-1:W]);
            check({tag, ":lo"}, lo, e[W-1:0]);
            check({tag, ":div_zero"}, {31'b0, div_zero}, {31'b0, e[2*W]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        logic [2*W-1:0] ref_p;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;

        // op, A, B, expected HI, expected LO, div_zero, busy cycles
        vecs[0]  = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5};
        vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 5};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10};
        vecs[3]  = '{MDU_MTHI,  32'h00000011, 32'h00000000, 32'h00000011, 32'hFFFFFFFD, 1'b0, 0};
        vecs[4]  = '{MDU_MTLO,  32'h00000022, 32'h00000000, 32'h00000011, 32'h00000022, 1'b0, 0};
        vecs[5]  = '{MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000011, 32'h00000022, 1'b1, 10};
        vecs[6]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 10};
        vecs[7]  = '{MDU_MTHI,  32'h00000000, 32'h00000000, 32'h00000000, 32'h80000000, 1'b0, 0};
        vecs[8]  = '{MDU_MTLO,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0};
        vecs[9]  = '{MDU_MADDU, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 5};
        vecs[10] = '{MDU_MSUB,  32'h00000001, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 5};
        vecs[11] = '{4'd12,     32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0};
        vecs[12] = '{MDU_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 10};
        vecs[13] = '{MDU_MADD,  32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'h00000008, 1'b0, 5};
        vecs[14] = '{MDU_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000004, 32'h00000007, 1'b0, 5};
        vecs[15] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 10};

        // Clock/reset
        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:busy", {31'b0, busy}, 32'd0);
        check("reset:hi", hi, 32'd0);
        check("reset:lo", lo, 32'd0);
        check("reset:div_zero", {31'b0, div_zero}, 32'd0);
        check("reset:state", {31'b0, dbg_state}, {31'b0, ST_IDLE});
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table: each op is issued in the completion cycle of the previous one
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].edz);
            wait_done($sformatf("vec%0d", i), vecs[i].ncyc - ((vecs[i].ncyc > 0) ? 0 : 0));
        end

        // Random unsigned multiplies/divides against a 64-bit reference
        for (int i = 0; i < 8; i++) begin
            ra = $urandom();
            if (i % 2 == 0) begin
                rb    = $urandom();
                ref_p = 64'(ra) * 64'(rb);
                issue(MDU_MULTU, ra, rb, ref_p[2*W-1:W], ref_p[W-1:0], 1'b0);
                wait_done($sformatf("rnd_multu%0d", i), 5);
            end else begin
                rb = 32'($urandom_range(1, 1000));
                issue(MDU_DIVU, ra, rb, ra % rb, ra / rb, 1'b0);
                wait_done($sformatf("rnd_divu%0d", i), 10);
            end
        end

        // Starts while busy must be ignored: mult 3*5 with an mtlo and a
        // second mult pulsed during its first two busy cycles
        issue(MDU_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        start = 1'b1;
        op    = MDU_MTLO;
        a     = 32'h0000DEAD;
        @(posedge clk);
        #1;
        op = MDU_MULT;
        a  = 32'd7;
        b  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        wait_done("ignore", 3);
        @(posedge clk);
        #1;
        check("ignore:no_restart", {31'b0, busy}, 32'd0);
        check("ignore:lo_hold", lo, 32'd15);

        // Async reset in the third busy cycle of a mult
        issue(MDU_MTHI, 32'h55, 32'd0, 32'h55, 32'd15, 1'b0);
        wait_done("mthi55", 0);
        start = 1'b1;
        op    = MDU_MULT;
        a     = 32'd2;
        b     = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset:busy", {31'b0, busy}, 32'd0);
        check("midreset:hi", hi, 32'd0);
        check("midreset:lo", lo, 32'd0);
        check("midreset:div_zero", {31'b0, div_zero}, 32'd0);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("postreset:busy", {31'b0, busy}, 32'd0);
        check("postreset:hi", hi, 32'd0);
        check("postreset:lo", lo, 32'd0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard leftover entries=%0d", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
